// File: rtl/ifetch_tag_stage.sv
// rtl/ifetch_tag_stage.sv - per-SM fetch tag stage: thread PCs, round-robin pick, L1I tag read
// Miss-blocked threads sleep until their L2 fill; rollback overrides miss/fill on the same thread.
module ifetch_tag_stage #(
    parameter int          NUM_THREADS = 4,
    parameter int          LINE_BYTES  = 64,
    parameter int          L1I_SETS    = 16,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_THREADS-1:0]         thread_en,
    input  logic                           ifd_ready,
    input  logic                           ifd_cache_miss,
    input  logic [$clog2(NUM_THREADS)-1:0] ifd_cache_miss_thread_idx,
    input  logic [31:0]                    ifd_cache_miss_pc,
    input  logic                           l2i_fill_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] l2i_fill_thread_idx,
    input  logic                           rollback_en,
    input  logic [$clog2(NUM_THREADS)-1:0] rollback_thread_idx,
    input  logic [31:0]                    rollback_pc,
    output logic                           ift_tag_read_en,
    output logic [$clog2(L1I_SETS)-1:0]    ift_tag_read_set,
    output logic                           ift_instruction_requested,
    output logic [31:0]                    ift_pc,
    output logic [$clog2(NUM_THREADS)-1:0] ift_thread_idx
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int SW = $clog2(L1I_SETS);
    localparam int OW = $clog2(LINE_BYTES);

    logic [31:0]            r_pc [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_waiting;
    logic [TW-1:0]          r_last_grant;
    logic                   r_req;
    logic [31:0]            r_ift_pc;
    logic [TW-1:0]          r_ift_idx;

    logic [NUM_THREADS-1:0] w_eligible;
    logic                   w_grant_valid;
    logic [TW-1:0]          w_grant_idx;
    logic [31:0]            w_rb_pc;
    logic [31:0]            w_miss_pc;
    logic                   w_unused_pc_lsbs;

    assign w_rb_pc          = {rollback_pc[31:2], 2'b00};
    assign w_miss_pc        = {ifd_cache_miss_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs = ^{rollback_pc[1:0], ifd_cache_miss_pc[1:0]};

    // A thread being redirected or reported missing this cycle must not be fetched from its stale PC.
    always_comb begin
        w_eligible = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_eligible[t] = thread_en[t] & ~r_waiting[t]
                          & ~(rollback_en && (rollback_thread_idx == TW'(t)))
                          & ~(ifd_cache_miss && (ifd_cache_miss_thread_idx == TW'(t)));
        end
    end

    // Scan from farthest to nearest offset so the nearest eligible thread after last_grant wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = r_last_grant;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            if (w_eligible[r_last_grant + TW'(k)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = r_last_grant + TW'(k);
            end
        end
        w_grant_valid = w_grant_valid & ifd_ready;
    end

    assign ift_tag_read_en           = w_grant_valid & ~reset;
    assign ift_tag_read_set          = r_pc[w_grant_idx][OW +: SW];
    assign ift_instruction_requested = r_req;
    assign ift_pc                    = r_ift_pc;
    assign ift_thread_idx            = r_ift_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= RESET_PC & ~32'h3;
            end
            r_waiting    <= '0;
            r_last_grant <= TW'(NUM_THREADS - 1);
            r_req        <= 1'b0;
            r_ift_pc     <= 32'h0;
            r_ift_idx    <= '0;
        end else begin
            r_req <= w_grant_valid;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
                r_ift_pc     <= r_pc[w_grant_idx];
                r_ift_idx    <= w_grant_idx;
            end
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (rollback_en && (rollback_thread_idx == TW'(t))) begin
                    r_pc[t]      <= w_rb_pc;
                    r_waiting[t] <= 1'b0;
                end else if (ifd_cache_miss && (ifd_cache_miss_thread_idx == TW'(t))) begin
                    r_pc[t]      <= w_miss_pc;
                    r_waiting[t] <= 1'b1;
                end else begin
                    if (l2i_fill_valid && (l2i_fill_thread_idx == TW'(t))) begin
                        r_waiting[t] <= 1'b0;
                    end
                    if (w_grant_valid && (w_grant_idx == TW'(t))) begin
                        r_pc[t] <= r_pc[t] + 32'd4;
                    end
                end
            end
        end
    end
endmodule
